clk_phase_sel_ctrl: RTL and testbench

// Select generator for the glitch-free phase-clock mux tree (BUFGMUX_CTRL levels) behind the clock randomizer.

---
 rtl/clk_rand_pkg.sv | 46 ++++
 rtl/clk_phase_sel_ctrl_if.sv | 26 ++
 rtl/lfsr_gen.sv | 43 ++++
 rtl/clk_phase_sel_ctrl.sv | 107 ++++++++++
 tb/tb_clk_phase_sel_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/clk_rand_pkg.sv
// Shared definitions for the clock-randomizer countermeasure blocks:
// selection modes, LFSR defaults and phase-index arithmetic.
package clk_rand_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_RANDOM = 2'd1,
        MODE_SWEEP  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    // Phase indices are handled at 7 bits so up to 64 phases fit with headroom.
    localparam int IDX_W = 7;

    function automatic logic [31:0] lfsr_default_taps(input int w);
        logic [31:0] taps;
        case (w)
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            24:      taps = 32'h00E1_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_B400;
        endcase
        return taps;
    endfunction

    function automatic logic [31:0] lfsr_default_seed(input int w);
        logic [31:0] seed;
        case (w)
            8:       seed = 32'h0000_00E1;
            default: seed = 32'h0000_ACE1;
        endcase
        return seed;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] c,
                                                  input logic [IDX_W-1:0] n);
        return (c >= n) ? (c - n) : c;
    endfunction

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] c,
                                                 input logic [IDX_W-1:0] n);
        return ((c + 7'd1) >= n) ? 7'd0 : (c + 7'd1);
    endfunction

endpackage

// File: rtl/clk_phase_sel_ctrl_if.sv
// Control/status bundle between a host and the phase-select generator.
interface clk_phase_sel_ctrl_if #(
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16,
    parameter int LFSR_W = 16
);
    logic              en;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  period;
    logic [SEL_W-1:0]  fixed_sel;
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic [SEL_W-1:0]  sel;
    logic              sel_valid;
    logic              switch_pulse;

    modport master (
        output en, mode, period, fixed_sel, seed_load, seed,
        input  sel, sel_valid, switch_pulse
    );

    modport slave (
        input  en, mode, period, fixed_sel, seed_load, seed,
        output sel, sel_valid, switch_pulse
    );
endinterface

// File: rtl/lfsr_gen.sv
// Galois LFSR with seed load; a zero seed falls back to SEED_DEF so the
// all-zero lockup state can never be entered.
module lfsr_gen
    import clk_rand_pkg::*;
#(
    parameter int           W        = 16,
    parameter logic [W-1:0] TAPS     = W'(lfsr_default_taps(W)),
    parameter logic [W-1:0] SEED_DEF = W'(lfsr_default_seed(W))
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d;

    // Next state: load beats shift and works even while frozen.
    always_comb begin
        q_d = q;
        if (load) begin
            if (seed == {W{1'b0}}) begin
                q_d = SEED_DEF;
            end else begin
                q_d = seed;
            end
        end else if (en) begin
            q_d = {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : {W{1'b0}});
        end else begin
            q_d = q;
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            q <= SEED_DEF;
        end else begin
            q <= q_d;
        end
    end
endmodule

// File: rtl/clk_phase_sel_ctrl.sv
// Select generator for the glitch-free phase-clock mux tree: picks a new
// phase index every max(period, MIN_DWELL) enabled cycles and holds it registered.
module clk_phase_sel_ctrl
    import clk_rand_pkg::*;
#(
    parameter int                NUM_PHASES = 8,
    parameter int                SEL_W      = $clog2(NUM_PHASES),
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(lfsr_default_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0] SEED_DEF   = LFSR_W'(lfsr_default_seed(LFSR_W)),
    parameter int                CNT_W      = 16,
    parameter int                MIN_DWELL  = 4,
    parameter bit                NO_REPEAT  = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst,
    clk_phase_sel_ctrl_if.slave   bus
);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(NUM_PHASES);
    localparam logic [CNT_W-1:0] DWELL    = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(MIN_DWELL - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              pulse_q, pulse_d;
    logic              valid_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [CNT_W-1:0]  term_s;
    logic              tc_s;
    logic [IDX_W-1:0]  cur_s, rnd_s, nxt_s;
    mode_e             mode_s;

    lfsr_gen #(
        .W        (LFSR_W),
        .TAPS     (LFSR_TAPS),
        .SEED_DEF (SEED_DEF)
    ) u_lfsr (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (bus.en),
        .load   (bus.seed_load),
        .seed   (bus.seed),
        .q      (lfsr_q)
    );

    // Terminal count uses >= so a shrinking period switches on the next edge.
    assign term_s = (bus.period < DWELL) ? DWELL_M1 : (bus.period - CNT_W'(1));
    assign tc_s   = (cnt_q >= term_s);
    assign mode_s = mode_e'(bus.mode);
    assign cur_s  = IDX_W'(sel_q);
    assign rnd_s  = wrap_idx(IDX_W'(lfsr_q[SEL_W-1:0]), N_IDX);

    // Candidate index for the next switch, from the pre-load LFSR value.
    always_comb begin
        nxt_s = cur_s;
        case (mode_s)
            MODE_FIXED:  nxt_s = wrap_idx(IDX_W'(bus.fixed_sel), N_IDX);
            MODE_RANDOM: begin
                if (NO_REPEAT && (rnd_s == cur_s)) begin
                    nxt_s = inc_idx(rnd_s, N_IDX);
                end else begin
                    nxt_s = rnd_s;
                end
            end
            MODE_SWEEP:  nxt_s = inc_idx(cur_s, N_IDX);
            MODE_HOLD:   nxt_s = cur_s;
            default:     nxt_s = cur_s;
        endcase
    end

    // Interval counter and switch decision.
    always_comb begin
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        pulse_d = 1'b0;
        if (bus.en) begin
            if (tc_s) begin
                cnt_d   = {CNT_W{1'b0}};
                sel_d   = nxt_s[SEL_W-1:0];
                pulse_d = (nxt_s != cur_s);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q   <= {CNT_W{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pulse_q <= pulse_d;
            valid_q <= 1'b1;
        end
    end

    assign bus.sel          = sel_q;
    assign bus.sel_valid    = valid_q;
    assign bus.switch_pulse = pulse_q;
endmodule

// File: tb/tb_clk_phase_sel_ctrl.sv
// Scoreboard bench: two instances (8 and 6 phases) share one stimulus stream
// and are compared every cycle against a behavioural model of the selection rules.
module tb_clk_phase_sel_ctrl;
    import clk_rand_pkg::*;

    typedef struct {
        int sel;
        bit valid;
        bit pulse;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_r;
    logic [1:0]  mode_r;
    logic [15:0] period_r;
    logic [2:0]  fixed_r;
    logic        sl_r;
    logic [15:0] seed_r;

    int checks   = 0;
    int failures = 0;

    exp_t        q8[$];
    exp_t        q6[$];
    int          m_cnt  [2];
    int          m_sel  [2];
    logic [15:0] m_lfsr [2];
    bit          m_valid[2];
    bit          m_pulse[2];
    int          m_rsw = 0;

    always #5 clk = ~clk;

    clk_phase_sel_ctrl_if #(.SEL_W(3), .CNT_W(16), .LFSR_W(16)) if8 ();
    clk_phase_sel_ctrl_if #(.SEL_W(3), .CNT_W(16), .LFSR_W(16)) if6 ();

    assign if8.en = en_r;        assign if6.en = en_r;
    assign if8.mode = mode_r;    assign if6.mode = mode_r;
    assign if8.period = period_r; assign if6.period = period_r;
    assign if8.fixed_sel = fixed_r; assign if6.fixed_sel = fixed_r;
    assign if8.seed_load = sl_r; assign if6.seed_load = sl_r;
    assign if8.seed = seed_r;    assign if6.seed = seed_r;

    clk_phase_sel_ctrl #(.NUM_PHASES(8)) dut8 (.clk_in(clk), .rst(rst), .bus(if8));
    clk_phase_sel_ctrl #(.NUM_PHASES(6)) dut6 (.clk_in(clk), .rst(rst), .bus(if6));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one step per rising edge, expected outputs queued.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int n, ivl, c;
            n = (k == 0) ? 8 : 6;
            if (rst) begin
                m_cnt[k] = 0; m_sel[k] = 0; m_lfsr[k] = 16'hACE1;
                m_valid[k] = 1'b0; m_pulse[k] = 1'b0;
            end else begin
                m_valid[k] = 1'b1;
                m_pulse[k] = 1'b0;
                ivl = (int'(period_r) > 4) ? int'(period_r) : 4;
                if (en_r) begin
                    if (m_cnt[k] + 1 >= ivl) begin
                        case (mode_r)
                            2'd0: c = int'(fixed_r) % n;
                            2'd1: begin
                                c = int'(m_lfsr[k]) % 8;
                                if (c >= n) c = c - n;
                                if (c == m_sel[k]) c = (c + 1) % n;
                                if (k == 1) m_rsw++;
                            end
                            2'd2: c = (m_sel[k] + 1) % n;
                            default: c = m_sel[k];
                        endcase
                        m_pulse[k] = (c != m_sel[k]);
                        m_sel[k] = c;
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                if (sl_r) m_lfsr[k] = (seed_r == 16'h0000) ? 16'hACE1 : seed_r;
                else if (en_r) m_lfsr[k] = m_lfsr[k][0] ? ((m_lfsr[k] >> 1) ^ 16'hB400) : (m_lfsr[k] >> 1);
            end
            if (k == 0) q8.push_back('{m_sel[k], m_valid[k], m_pulse[k]});
            else        q6.push_back('{m_sel[k], m_valid[k], m_pulse[k]});
        end
    end

    // Monitor: compare every presented output cycle against the queued model response.
    always @(negedge clk) begin
        exp_t e;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("sel8", int'(if8.sel), e.sel);
            chk("valid8", int'(if8.sel_valid), int'(e.valid));
            chk("pulse8", int'(if8.switch_pulse), int'(e.pulse));
        end
        if (q6.size() > 0) begin
            e = q6.pop_front();
            chk("sel6", int'(if6.sel), e.sel);
            chk("valid6", int'(if6.sel_valid), int'(e.valid));
            chk("pulse6", int'(if6.switch_pulse), int'(e.pulse));
            chk("sel6_range", int'(if6.sel < 3'd6), 1);
        end
    end

    initial begin
        int pulses;
        int guard;
        int base;
        logic [3:0] nine;
        rst = 1'b1; en_r = 1'b0; mode_r = 2'd0; period_r = 16'd5;
        fixed_r = 3'd0; sl_r = 1'b0; seed_r = 16'h0000;

        // Reset release
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid_first", int'(if8.sel_valid), 0);
        chk("rst_sel", int'(if8.sel), 0);
        chk("rst_pulse", int'(if8.switch_pulse), 0);
        @(negedge clk);
        chk("rst_valid_next", int'(if8.sel_valid), 1);

        // Sweep with period 5: eight steps in 40 cycles
        en_r = 1'b1; mode_r = 2'd2; period_r = 16'd5;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (if8.switch_pulse) pulses++;
        end
        chk("sweep_pulses", pulses, 8);
        chk("sweep_wrap_sel", int'(if8.sel), 0);

        // Period below minimum dwell
        period_r = 16'd1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.switch_pulse) pulses++;
        end
        chk("min_dwell_pulses", pulses, 3);

        // Shrink period with the counter mid-interval
        period_r = 16'd20;
        guard = 0;
        while (m_cnt[0] != 10 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("shrink_reach_cnt10", int'(guard < 100), 1);
        period_r = 16'd3;
        @(negedge clk);
        chk("shrink_pulse", int'(if8.switch_pulse), 1);
        chk("shrink_cnt", int'(dut8.cnt_q), 0);

        // Zero seed falls back to default; en=0 freezes everything
        en_r = 1'b0; sl_r = 1'b1; seed_r = 16'h0000;
        @(negedge clk);
        sl_r = 1'b0;
        chk("seed0_lfsr", int'(dut8.u_lfsr.q), 16'hACE1);
        repeat (50) @(negedge clk);
        chk("frozen_lfsr", int'(dut8.u_lfsr.q), 16'hACE1);
        chk("frozen_cnt", int'(dut8.cnt_q), m_cnt[0]);
        chk("frozen_pulse", int'(if8.switch_pulse), 0);

        // Random mode on six phases, seed 1, 1000 switches
        mode_r = 2'd1; sl_r = 1'b1; seed_r = 16'h0001;
        @(negedge clk);
        sl_r = 1'b0; en_r = 1'b1; period_r = 16'd0;
        base = m_rsw;
        guard = 0;
        while ((m_rsw - base) < 1000 && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        chk("random_1000_switches", int'((m_rsw - base) >= 1000), 1);

        // Randomized mixed stimulus
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 99) == 0);
            en_r   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) mode_r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) period_r = 16'($urandom_range(0, 9));
            fixed_r = 3'($urandom_range(0, 7));
            sl_r   = ($urandom_range(0, 19) == 0);
            seed_r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; sl_r = 1'b0;

        // Fixed mode, out-of-range index, then reset mid-interval
        en_r = 1'b1; mode_r = 2'd0; period_r = 16'd5; fixed_r = 3'd3;
        repeat (6) @(negedge clk);
        chk("fixed3_sel8", int'(if8.sel), 3);
        chk("fixed3_sel6", int'(if6.sel), 3);
        nine = 4'd9;
        fixed_r = nine[2:0];
        repeat (6) @(negedge clk);
        chk("fixed9_sel8", int'(if8.sel), 1);
        fixed_r = 3'd7;
        repeat (6) @(negedge clk);
        chk("fixed7_sel6_wrap", int'(if6.sel), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sel", int'(if8.sel), 0);
        chk("midrst_pulse", int'(if8.switch_pulse), 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
